int_tx_multibyte: RTL
=====================

Name: int_tx_multibyte

Overview:
Parametrised successor to the ALU→TX-FIFO interface. On a start request it captures an ALU result of DATA_WIDTH bits and writes it into the UART TX FIFO as DATA_WIDTH/8 consecutive bytes. Byte order is selectable, and an optional header byte is sent first. Byte writes honour fifo_full backpressure. Sits between the ALU result register and the TX FIFO write port.

Parameters:
DATA_WIDTH, 32, width of DATO_ALU; multiple of 8, range 8..64; NB = DATA_WIDTH/8.
MSB_FIRST, 0, 0 = least-significant byte sent first; 1 = most-significant byte first.
HEADER_EN, 0, 1 = send HEADER_BYTE before the data bytes.
HEADER_BYTE, 8'hAA, value of the header byte.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-high reset.
enviar  input  1  start request; only a 0→1 transition is acted on.
fifo_full  input  1  TX FIFO full; no write while high.
DATO_ALU  input  DATA_WIDTH  ALU result; sampled only at start.
WR_FIFO  output  1  FIFO write strobe; one byte per cycle it is high.
data_fifo  output  8  byte presented to the FIFO; valid when WR_FIFO=1.
busy  output  1  high from start until the last byte is written.
done  output  1  one-cycle pulse after the last byte is written.

Behaviour:
- Reset (async, immediate): state IDLE; enviar_prev=0; shift register=0; byte counter=0; WR_FIFO=0, data_fifo=8'h00, busy=0, done=0.
- Start detect: start = enviar & ~enviar_prev. enviar_prev is registered every cycle, including while busy. A held-high enviar triggers exactly once. enviar high at reset release counts as a start.
- States: IDLE, HDR, SEND, DONE.
  - IDLE: on start, load shift register ← DATO_ALU and counter ← NB. Go to HDR if HEADER_EN, else SEND. Start is ignored in any state other than IDLE.
  - HDR: data_fifo = HEADER_BYTE. On an edge with WR_FIFO=1, go to SEND.
  - SEND: data_fifo = current byte, which is shreg[7:0] (MSB_FIRST=0) or shreg[DATA_WIDTH-1 -: 8] (MSB_FIRST=1). On an edge with WR_FIFO=1: shift the register by 8 toward the current-byte end (zero fill) and decrement the counter. When the counter goes 1→0, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. A start seen in DONE is ignored.
- WR_FIFO is combinational: (state==HDR | state==SEND) & ~fifo_full. This gives same-cycle backpressure, so the FIFO is never written while full.
- data_fifo is a combinational mux of state and shift register. It is 8'h00 in IDLE and DONE.
- busy = (state==HDR | state==SEND). done is registered.
- Latency: a start sampled at edge k puts the FIFO in the first write-eligible cycle k..k+1. With no backpressure, NB writes (NB+1 with header) occupy consecutive cycles. done is high in the cycle after the last write.
- Backpressure: while fifo_full=1, state, counter and shift register hold, and data_fifo stays stable. Writing resumes the same cycle fifo_full drops.
- DATO_ALU changes after capture do not affect the transfer in progress.
- RESET mid-transfer aborts immediately: WR_FIFO drops asynchronously and no remaining bytes are written. No done pulse is issued.
- Counter width is clog2(NB+1). It does not wrap because it is only decremented in SEND while nonzero.

Test Plan:
- DATA_WIDTH=8, DATO_ALU=55, enviar high 10 cycles, fifo_full=0 → exactly one write of 8'h37; done pulses once; no retrigger.
- DATA_WIDTH=32, MSB_FIRST=0, DATO_ALU=32'h11223344, single start → writes 44,33,22,11 on 4 consecutive cycles; busy high 4 cycles; done pulse the next cycle.
- Same with MSB_FIRST=1 and HEADER_EN=1 → writes AA,11,22,33,44; busy high 5 cycles.
- MSB_FIRST=0, 32'h11223344, fifo_full held high for 3 cycles after the second write → no WR_FIFO during the stall; data_fifo holds 8'h22; sequence completes 44,33,22,11 with no loss or duplicate.
- Start, then DATO_ALU←32'hDEADBEEF and a second enviar pulse while busy → original 4 bytes only; second pulse ignored.
- RESET asserted after 2 of 4 writes → WR_FIFO=0, busy=0, data_fifo=00 immediately; no further writes and no done; a fresh start afterwards sends the full new word.

Source files
------------

// File: rtl/int_tx_multibyte_if.sv
// Start/FIFO-side signal bundle for int_tx_multibyte; DATA_WIDTH must match the attached module.
interface int_tx_multibyte_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  enviar;
   logic                  fifo_full;
   logic [DATA_WIDTH-1:0] DATO_ALU;
   logic                  WR_FIFO;
   logic [7:0]            data_fifo;
   logic                  busy;
   logic                  done;

   modport master (
      output enviar, fifo_full, DATO_ALU,
      input  WR_FIFO, data_fifo, busy, done
   );

   modport slave (
      input  enviar, fifo_full, DATO_ALU,
      output WR_FIFO, data_fifo, busy, done
   );
endinterface

// File: rtl/int_tx_multibyte.sv
// Captures a DATA_WIDTH-bit ALU result on a rising enviar and writes it to the TX FIFO
// as DATA_WIDTH/8 bytes, optionally preceded by a header byte, honouring fifo_full.
module int_tx_multibyte #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter bit          MSB_FIRST   = 1'b0,
   parameter bit          HEADER_EN   = 1'b0,
   parameter logic [7:0]  HEADER_BYTE = 8'hAA
) (
   input logic          CLK,
   input logic          RESET,
   int_tx_multibyte_if.slave bus
);

   localparam int unsigned NB = DATA_WIDTH / 8;
   localparam int unsigned CW = $clog2(NB + 1);

   typedef enum logic [1:0] {IDLE, HDR, SEND, DONE} state_t;

   state_t                state_q, state_d;
   logic                  enviar_prev_q;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  done_q;

   logic                  start;
   logic                  wr;
   logic                  busy;
   logic [7:0]            data;
   logic [7:0]            cur_byte;

   assign start    = bus.enviar & ~enviar_prev_q;
   assign cur_byte = MSB_FIRST ? shreg_q[DATA_WIDTH-1 -: 8] : shreg_q[7:0];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q       <= IDLE;
         enviar_prev_q <= 1'b0;
         shreg_q       <= '0;
         cnt_q         <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         enviar_prev_q <= bus.enviar;
         shreg_q       <= shreg_d;
         cnt_q         <= cnt_d;
         done_q        <= (state_d == DONE);
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      wr      = 1'b0;
      busy    = 1'b0;
      data    = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = bus.DATO_ALU;
               cnt_d   = CW'(NB);
               state_d = HEADER_EN ? HDR : SEND;
            end
         end
         HDR: begin
            busy = 1'b1;
            wr   = ~bus.fifo_full;
            data = HEADER_BYTE;
            if (wr) state_d = SEND;
         end
         SEND: begin
            busy = 1'b1;
            wr   = ~bus.fifo_full;
            data = cur_byte;
            // Consumed byte is shifted out with zero fill; counter tracks bytes still owed.
            if (wr) begin
               shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
               cnt_d   = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.WR_FIFO   = wr;
   assign bus.data_fifo = data;
   assign bus.busy      = busy;
   assign bus.done      = done_q;

endmodule
